// File: rtl/rm_dfx_sequencer_if.sv
// rm_dfx_sequencer_if: PR-controller / RP-boundary / LED bundle around rm_dfx_sequencer
// Inputs to the sequencer: pr_req (level), pr_done/pr_err/sw_reset (1-cycle pulses), rm_led (RM LED value).
// Outputs from the sequencer: pr_ack, decouple, rm_rst, led_out, busy, error, state_dbg (all registered).
interface rm_dfx_sequencer_if #(parameter int LED_W = 4);
  logic             pr_req;
  logic             pr_done;
  logic             pr_err;
  logic             sw_reset;
  logic [LED_W-1:0] rm_led;
  logic             pr_ack;
  logic             decouple;
  logic             rm_rst;
  logic [LED_W-1:0] led_out;
  logic             busy;
  logic             error;
  logic [2:0]       state_dbg;
  modport slave (input pr_req, pr_done, pr_err, sw_reset, rm_led,
                 output pr_ack, decouple, rm_rst, led_out, busy, error, state_dbg);
  modport master (output pr_req, pr_done, pr_err, sw_reset, rm_led,
                  input pr_ack, decouple, rm_rst, led_out, busy, error, state_dbg);
endinterface

// File: rtl/rm_dfx_sequencer.sv
// rm_dfx_sequencer: decouples, freezes and resets the LED-counter RM around partial reconfiguration
// Ports: clk, rst (sync, active-high); bus (slave modport) carries the PR handshake,
// the RM LED input and the registered decouple / rm_rst / led_out / status outputs.
module rm_dfx_sequencer #(
  parameter int LED_W           = 4,
  parameter int SETTLE_CYCLES   = 2,
  parameter int RST_HOLD_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 16777215
) (
  input logic                clk,
  input logic                rst,
  rm_dfx_sequencer_if.slave  bus
);
  localparam int MX = SETTLE_CYCLES > RST_HOLD_CYCLES ? SETTLE_CYCLES : RST_HOLD_CYCLES;
  localparam int CW = $clog2(MX + 1);
  localparam int TW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LD   = CW'(RST_HOLD_CYCLES - 1);
  typedef enum logic [2:0] {
    RUN = 3'd0, DECOUPLE = 3'd1, WAIT_PR = 3'd2, RESET_RM = 3'd3, RELEASE = 3'd4, ERROR = 3'd5
  } state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic             pr_req_q;
  logic             pr_ack_q, pr_ack_d;
  logic             decouple_q, decouple_d;
  logic             rm_rst_q, rm_rst_d;
  logic             busy_q, busy_d;
  logic             error_q, error_d;
  logic [LED_W-1:0] led_q, led_d;
  logic             tmo;
  // tcnt_q counts completed WAIT_PR cycles, so reaching TIMEOUT_CYCLES-1 means this edge is the last one
  assign tmo = (TIMEOUT_CYCLES != 0) && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN:
        if (bus.pr_req) begin state_d = DECOUPLE; cnt_d = SETTLE_LD; end
        else if (bus.sw_reset) begin state_d = RESET_RM; cnt_d = HOLD_LD; end
      DECOUPLE:
        if (!bus.pr_req) begin state_d = RESET_RM; cnt_d = HOLD_LD; end
        else if (cnt_q == '0) state_d = WAIT_PR;
        else cnt_d = cnt_q - CW'(1);
      WAIT_PR:
        if (bus.pr_err || tmo) state_d = ERROR;
        else if (bus.pr_done || !bus.pr_req) begin state_d = RESET_RM; cnt_d = HOLD_LD; end
      RESET_RM:
        if (cnt_q == '0) state_d = RELEASE;
        else cnt_d = cnt_q - CW'(1);
      RELEASE: state_d = RUN;
      ERROR: if (bus.pr_req && !pr_req_q) state_d = WAIT_PR;
      default: begin state_d = RESET_RM; cnt_d = HOLD_LD; end
    endcase
    // cleared outside WAIT_PR so every entry (including a retry) starts from zero; saturates, never wraps
    tcnt_d     = state_q != WAIT_PR ? '0 : (tcnt_q == TW'(TIMEOUT_CYCLES) ? tcnt_q : tcnt_q + TW'(1));
    pr_ack_d   = state_d == WAIT_PR;
    decouple_d = state_d != RUN;
    rm_rst_d   = state_d inside {WAIT_PR, RESET_RM, ERROR};
    busy_d     = state_d != RUN;
    error_d    = state_d == ERROR;
    led_d      = state_q == RUN ? bus.rm_led : led_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RESET_RM;
      cnt_q      <= HOLD_LD;
      tcnt_q     <= '0;
      pr_req_q   <= 1'b0;
      pr_ack_q   <= 1'b0;
      decouple_q <= 1'b1;
      rm_rst_q   <= 1'b1;
      busy_q     <= 1'b1;
      error_q    <= 1'b0;
      led_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tcnt_q     <= tcnt_d;
      pr_req_q   <= bus.pr_req;
      pr_ack_q   <= pr_ack_d;
      decouple_q <= decouple_d;
      rm_rst_q   <= rm_rst_d;
      busy_q     <= busy_d;
      error_q    <= error_d;
      led_q      <= led_d;
    end
  end
  assign bus.pr_ack    = pr_ack_q;
  assign bus.decouple  = decouple_q;
  assign bus.rm_rst    = rm_rst_q;
  assign bus.busy      = busy_q;
  assign bus.error     = error_q;
  assign bus.led_out   = led_q;
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_rm_dfx_sequencer.sv
// tb_rm_dfx_sequencer: randomized scenario bench for rm_dfx_sequencer against a state-table reference model
module tb_rm_dfx_sequencer;
  localparam int S_RUN = 0, S_DEC = 1, S_WAIT = 2, S_RST = 3, S_REL = 4, S_ERR = 5;
  localparam int HOLD = 16;
  typedef struct packed {
    logic       r;
    logic       req;
    logic       done;
    logic       err;
    logic       sw;
    logic [3:0] led;
  } stim_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  rm_dfx_sequencer_if #(.LED_W(4)) bus ();
  rm_dfx_sequencer #(.LED_W(4), .SETTLE_CYCLES(2), .RST_HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  int tests = 0;
  int fails = 0;
  stim_t stim_q[$];
  int exp_q[$];
  logic [12:0] obs_q[$];
  logic [3:0] led_m = '0;
  int prev_st = S_RST;
  logic [12:0] want;
  // expected {pr_ack, decouple, rm_rst, busy, error, state, led_out} for a state reached after an edge
  function automatic logic [12:0] exp_vec(input int st, input logic [3:0] led);
    logic [4:0] f;
    case (st)
      S_RUN:   f = 5'b00000;
      S_DEC:   f = 5'b01010;
      S_WAIT:  f = 5'b11110;
      S_RST:   f = 5'b01110;
      S_REL:   f = 5'b01010;
      S_ERR:   f = 5'b01111;
      default: f = 5'bxxxxx;
    endcase
    return {f, 3'(st), led};
  endfunction
  // each entry: inputs held over one rising edge, and the state expected right after that edge
  task automatic add(input int st, input int n, input bit req, input bit done = 0,
                     input bit err = 0, input bit sw = 0, input bit r = 0);
    stim_t s;
    for (int i = 0; i < n; i++) begin
      s = {r, req, done, err, sw, 4'($urandom)};
      stim_q.push_back(s);
      exp_q.push_back(st);
    end
  endtask
  // random pr_req/pr_done/pr_err/sw_reset, for states that must ignore them
  task automatic noise(input int st, input int n);
    stim_t s;
    for (int i = 0; i < n; i++) begin
      s = {1'b0, 8'($urandom)};
      stim_q.push_back(s);
      exp_q.push_back(st);
    end
  endtask
  task automatic recover(input int n_run);
    noise(S_RST, HOLD - 1);
    add(S_REL, 1, 0);
    add(S_RUN, n_run, 0);
  endtask
  task automatic to_wait(input int extra);
    add(S_DEC, 2, 1);
    add(S_WAIT, 1 + extra, 1);
  endtask
  task automatic drive_all();
    obs_q.delete();
    foreach (stim_q[i]) begin
      {rst, bus.pr_req, bus.pr_done, bus.pr_err, bus.sw_reset, bus.rm_led} = stim_q[i];
      @(posedge clk);
      #1;
      obs_q.push_back({bus.pr_ack, bus.decouple, bus.rm_rst, bus.busy, bus.error, bus.state_dbg, bus.led_out});
    end
  endtask
  task automatic clear();
    stim_q.delete();
    exp_q.delete();
  endtask
  task automatic test_reset();
    clear();
    add(S_RST, 3, 0, 0, 0, 0, 1);
    recover(8);
    drive_all();
    for (int i = 0; i < exp_q.size(); i++) begin
      led_m = stim_q[i].r ? 4'h0 : (prev_st == S_RUN ? stim_q[i].led : led_m);
      prev_st = exp_q[i];
      want = exp_vec(exp_q[i], led_m);
      tests++;
      if (obs_q[i] !== want) begin
        fails++;
        $display("FAIL reset cyc %0d: got flags/st/led=%b want %b", i, obs_q[i], want);
      end
    end
  endtask
  task automatic test_nominal();
    stim_t s;
    clear();
    for (int k = 0; k < 3; k++) begin
      add(S_RUN, $urandom_range(1, 5), 0);
      s = {1'b0, 1'b1, 3'b000, 4'hA};
      stim_q.push_back(s);
      exp_q.push_back(S_DEC);
      add(S_DEC, 1, 1);
      add(S_WAIT, 1 + $urandom_range(0, 20), 1);
      add(S_RST, 1, 1, 1);
      recover(4);
    end
    drive_all();
    for (int i = 0; i < exp_q.size(); i++) begin
      led_m = stim_q[i].r ? 4'h0 : (prev_st == S_RUN ? stim_q[i].led : led_m);
      prev_st = exp_q[i];
      want = exp_vec(exp_q[i], led_m);
      tests++;
      if (obs_q[i] !== want) begin
        fails++;
        $display("FAIL nominal cyc %0d: got flags/st/led=%b want %b", i, obs_q[i], want);
      end
    end
  endtask
  task automatic test_error_retry();
    clear();
    add(S_RUN, 3, 0);
    to_wait($urandom_range(0, 15));
    add(S_ERR, 1, 1, 0, 1);
    add(S_ERR, 5, 1);
    add(S_ERR, 3, 0);
    add(S_WAIT, 1 + $urandom_range(0, 10), 1);
    add(S_RST, 1, 1, 1);
    recover(4);
    drive_all();
    for (int i = 0; i < exp_q.size(); i++) begin
      led_m = stim_q[i].r ? 4'h0 : (prev_st == S_RUN ? stim_q[i].led : led_m);
      prev_st = exp_q[i];
      want = exp_vec(exp_q[i], led_m);
      tests++;
      if (obs_q[i] !== want) begin
        fails++;
        $display("FAIL error_retry cyc %0d: got flags/st/led=%b want %b", i, obs_q[i], want);
      end
    end
  endtask
  task automatic test_timeout();
    clear();
    add(S_RUN, 2, 0);
    to_wait(99);
    add(S_ERR, 4, 1);
    add(S_ERR, 2, 0);
    add(S_WAIT, 100, 1);
    add(S_ERR, 1, 1);
    add(S_ERR, 1, 0);
    add(S_WAIT, 1, 1);
    add(S_RST, 1, 0);
    recover(3);
    drive_all();
    for (int i = 0; i < exp_q.size(); i++) begin
      led_m = stim_q[i].r ? 4'h0 : (prev_st == S_RUN ? stim_q[i].led : led_m);
      prev_st = exp_q[i];
      want = exp_vec(exp_q[i], led_m);
      tests++;
      if (obs_q[i] !== want) begin
        fails++;
        $display("FAIL timeout cyc %0d: got flags/st/led=%b want %b", i, obs_q[i], want);
      end
    end
  endtask
  task automatic test_races();
    clear();
    add(S_RUN, 2, 0);
    add(S_DEC, 1, 1, 0, 0, 1);
    add(S_DEC, 1, 1);
    add(S_WAIT, 3, 1);
    add(S_ERR, 1, 1, 1, 1);
    add(S_ERR, 1, 0);
    add(S_WAIT, 1, 1);
    add(S_RST, 1, 0);
    recover(3);
    add(S_DEC, 1, 1);
    if ($urandom_range(0, 1) == 1) add(S_DEC, 1, 1);
    add(S_RST, 1, 0);
    recover(3);
    add(S_RST, 1, 0, 0, 0, 1);
    recover(3);
    drive_all();
    for (int i = 0; i < exp_q.size(); i++) begin
      led_m = stim_q[i].r ? 4'h0 : (prev_st == S_RUN ? stim_q[i].led : led_m);
      prev_st = exp_q[i];
      want = exp_vec(exp_q[i], led_m);
      tests++;
      if (obs_q[i] !== want) begin
        fails++;
        $display("FAIL races cyc %0d: got flags/st/led=%b want %b", i, obs_q[i], want);
      end
    end
  endtask
  task automatic test_mid_reset();
    clear();
    add(S_RUN, 2, 0);
    to_wait(4);
    add(S_RST, 2, 1, 0, 0, 0, 1);
    recover(5);
    drive_all();
    for (int i = 0; i < exp_q.size(); i++) begin
      led_m = stim_q[i].r ? 4'h0 : (prev_st == S_RUN ? stim_q[i].led : led_m);
      prev_st = exp_q[i];
      want = exp_vec(exp_q[i], led_m);
      tests++;
      if (obs_q[i] !== want) begin
        fails++;
        $display("FAIL mid_reset cyc %0d: got flags/st/led=%b want %b", i, obs_q[i], want);
      end
    end
  endtask
  task automatic test_random();
    clear();
    for (int k = 0; k < 15; k++) begin
      add(S_RUN, $urandom_range(1, 6), 0);
      case ($urandom_range(0, 4))
        0: begin to_wait($urandom_range(0, 30)); add(S_RST, 1, 1, 1); end
        1: begin
          to_wait($urandom_range(0, 30));
          add(S_ERR, 1, 1, $urandom_range(0, 1), 1);
          add(S_ERR, $urandom_range(0, 3), 1);
          add(S_ERR, $urandom_range(1, 3), 0);
          add(S_WAIT, 1 + $urandom_range(0, 5), 1);
          add(S_RST, 1, 1, 1);
        end
        2: begin add(S_DEC, 1, 1); add(S_RST, 1, 0); end
        3: begin to_wait($urandom_range(0, 30)); add(S_RST, 1, 0); end
        default: add(S_RST, 1, 0, 0, 0, 1);
      endcase
      recover($urandom_range(1, 4));
    end
    drive_all();
    for (int i = 0; i < exp_q.size(); i++) begin
      led_m = stim_q[i].r ? 4'h0 : (prev_st == S_RUN ? stim_q[i].led : led_m);
      prev_st = exp_q[i];
      want = exp_vec(exp_q[i], led_m);
      tests++;
      if (obs_q[i] !== want) begin
        fails++;
        $display("FAIL random cyc %0d: got flags/st/led=%b want %b", i, obs_q[i], want);
      end
    end
  endtask
  initial begin
    bus.pr_req = 1'b0;
    bus.pr_done = 1'b0;
    bus.pr_err = 1'b0;
    bus.sw_reset = 1'b0;
    bus.rm_led = '0;
    test_reset();
    test_nominal();
    test_error_retry();
    test_timeout();
    test_races();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
